// File: rtl/grf_scoreboard.sv
// General register file with NUM_RD bypassed read ports and a per-register busy scoreboard.
// Optional write trace display is compiled in with `define GRF_TRACE_EN.
module grf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [31:0]              wr_pc,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     rsv_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              rsv_err_q, rsv_err_d;

    logic wr_commit;
    logic rsv_ok;

    assign wr_commit = wr_en && !(ZR && (wr_addr == '0));
    assign rsv_ok    = rsv_en && !flush && !(ZR && (rsv_addr == '0));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        regs_d = regs_q;
        if (wr_commit) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Order matters: writeback clears, flush clears all, then a new reservation wins (WAW chain).
    always_comb begin
        busy_d = busy_q;
        if (wr_commit) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        rsv_err_d = rsv_err_q;
        if (rsv_ok && busy_q[rsv_addr] && !(wr_commit && (wr_addr == rsv_addr))) begin
            rsv_err_d = 1'b1;
        end
    end

    // NOTE: the register array is reset because software-visible reset state is all zeros.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              wr_hit;

        assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
        assign is_zero = ZR && (addr == '0);
        assign wr_hit  = wr_en && (wr_addr == addr);

        assign rd_data[p*DATA_W +: DATA_W] = is_zero ? '0 :
                                             wr_hit  ? wr_data : regs_q[addr];
        assign rd_busy[p] = busy_q[addr] & ~wr_hit;
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt = busy_cnt + {{ADDR_W{1'b0}}, busy_q[i]};
        end
    end

    assign rsv_err = rsv_err_q;

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && wr_commit) begin
            $display("%0d@%h: $%0d <= %h", $time, wr_pc, wr_addr, wr_data);
        end
    end
`else
    // The PC only feeds the trace; fold it away when tracing is compiled out.
    logic unused_wr_pc;
    assign unused_wr_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard (default parameters, two read ports).
module tb_grf_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [31:0]              wr_pc;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;
    logic                     rsv_err;

    int n_checks = 0;
    int n_fail   = 0;

    grf_scoreboard #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_pc    (wr_pc),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt),
        .rsv_err  (rsv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_pc    = 32'h0000_3000;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;

        // Reset: a write held during reset must not land.
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h0000_1234;
        tick();
        tick();
        idle();
        reset = 1'b1;
        set_rd(5'd3, 5'd8);
        #1;
        check("reset_reg3", rd_data[31:0], 32'h0);
        check("reset_busy_cnt", busy_cnt, 6'd0);
        check("reset_rsv_err", rsv_err, 1'b0);
        check("reset_rd_busy", rd_busy, 2'b00);

        // Bypass on port 0, plain read on port 1.
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 32'hDEAD_BEEF;
        wr_pc   = 32'h0000_3004;
        set_rd(5'd8, 5'd3);
        #1;
        check("bypass_rd0", rd_data[31:0], 32'hDEAD_BEEF);
        check("bypass_rd1_other", rd_data[63:32], 32'h0);
        tick();
        idle();
        set_rd(5'd3, 5'd8);
        #1;
        check("after_write_rd1", rd_data[63:32], 32'hDEAD_BEEF);

        // Zero register: write and reservation both ignored.
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFF_FFFF;
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        check("zero_bypass_rd0", rd_data[31:0], 32'h0);
        check("zero_bypass_rd1", rd_data[63:32], 32'h0);
        tick();
        idle();
        #1;
        check("zero_rd0", rd_data[31:0], 32'h0);
        check("zero_busy", rd_busy, 2'b00);
        check("zero_busy_cnt", busy_cnt, 6'd0);

        // Scoreboard: reserve 5, then write it back.
        rsv_en   = 1'b1;
        rsv_addr = 5'd5;
        tick();
        idle();
        set_rd(5'd5, 5'd0);
        #1;
        check("sb_busy", rd_busy[0], 1'b1);
        check("sb_busy_cnt1", busy_cnt, 6'd1);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h0000_0042;
        #1;
        check("sb_hidden_busy", rd_busy[0], 1'b0);
        check("sb_bypass", rd_data[31:0], 32'h42);
        check("sb_cnt_before_edge", busy_cnt, 6'd1);
        tick();
        idle();
        #1;
        check("sb_cnt_after", busy_cnt, 6'd0);
        check("sb_rd5", rd_data[31:0], 32'h42);
        check("sb_no_err", rsv_err, 1'b0);

        // Collision: reg 7 busy, write and reserve 7 in the same cycle.
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        tick();
        wr_en    = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'h0000_0010;
        tick();
        idle();
        set_rd(5'd7, 5'd5);
        #1;
        check("col_data", rd_data[31:0], 32'h10);
        check("col_busy", rd_busy[0], 1'b1);
        check("col_busy_cnt", busy_cnt, 6'd1);
        check("col_no_err", rsv_err, 1'b0);
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        tick();
        idle();
        #1;
        check("col_err_set", rsv_err, 1'b1);
        tick();
        tick();
        check("col_err_sticky", rsv_err, 1'b1);
        check("col_cnt_still", busy_cnt, 6'd1);

        // Flush: reserve 2, 9, 31 (plus 7 already busy), then flush with a
        // reservation of 4 and a same-cycle write to 9.
        rsv_en   = 1'b1;
        rsv_addr = 5'd2;
        tick();
        rsv_addr = 5'd9;
        tick();
        rsv_addr = 5'd31;
        tick();
        idle();
        set_rd(5'd31, 5'd9);
        #1;
        check("fl_cnt_before", busy_cnt, 6'd4);
        check("fl_busy_pre", rd_busy, 2'b11);
        flush    = 1'b1;
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        wr_en    = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h0000_0099;
        tick();
        idle();
        set_rd(5'd4, 5'd9);
        #1;
        check("fl_cnt_after", busy_cnt, 6'd0);
        check("fl_reg4_busy", rd_busy[0], 1'b0);
        check("fl_write_commit", rd_data[63:32], 32'h99);
        check("fl_err_sticky", rsv_err, 1'b1);

        // Asynchronous reset mid-cycle clears state without a clock edge.
        rsv_en   = 1'b1;
        rsv_addr = 5'd12;
        tick();
        idle();
        set_rd(5'd12, 5'd8);
        #1;
        check("mid_pre_busy", rd_busy[0], 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_cnt", busy_cnt, 6'd0);
        check("mid_err", rsv_err, 1'b0);
        check("mid_reg8", rd_data[63:32], 32'h0);
        tick();
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 32'h0000_0005;
        tick();
        idle();
        #1;
        check("post_reset_write", rd_data[63:32], 32'h5);
        check("post_reset_cnt", busy_cnt, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU, successor to the fixed 2-read/1-write GRF.
- Provides NUM_RD combinational read ports with internal write-to-read bypass.
- Adds a per-register busy scoreboard. Multi-cycle units (mult/div, future load paths) reserve a destination register at issue, and the writeback clears the reservation.
- Sits between decode (reads, reservation) and writeback (write port).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 reads 0, is never written and is never busy

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  port i register has an outstanding reservation
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- wr_pc  input  32  PC of the writing instruction (trace only)
- rsv_en  input  1  reserve rsv_addr (mark busy)
- rsv_addr  input  ADDR_W  register to reserve
- flush  input  1  clear all busy bits (pipeline flush)
- busy_cnt  output  ADDR_W+1  number of busy registers
- rsv_err  output  1  sticky error flag: reservation of an already-busy register

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - all registers = 0, all busy bits = 0, rsv_err = 0
  - combinational outputs follow: rd_busy = 0, busy_cnt = 0, rd_data = 0 (unless bypassed)
- Write: on posedge clk with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - If ZERO_REG=1 and wr_addr=0, the write is ignored.
  - Writes to non-busy registers are legal.
- Read is combinational, zero latency, per port i:
  - if wr_en=1, wr_addr=rd_addr_i and the address is not the zero register: rd_data_i = wr_data (bypass)
  - otherwise rd_data_i = reg[rd_addr_i]
  - with ZERO_REG=1 and rd_addr_i=0: rd_data_i = 0, regardless of bypass
- rd_busy_i = busy[rd_addr_i] & ~(wr_en & wr_addr==rd_addr_i). A same-cycle writeback hides the busy bit.
- Reservation: on posedge with rsv_en=1 and flush=0, busy[rsv_addr] <= 1. Ignored for register 0 when ZERO_REG=1.
- Same-cycle write and reservation, same address:
  - data is written
  - busy ends at 1, because the new producer wins (WAW chain)
- flush=1 on posedge:
  - all busy bits <= 0; rsv_en is ignored that cycle
  - a write in the same cycle still commits
- rsv_err:
  - set on posedge when rsv_en=1, flush=0, the target is busy and it is not cleared by a same-cycle write
  - stays 1 until reset
- busy_cnt is the combinational popcount of the current busy bits, range 0..2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).
- Reset asserted mid-operation: state clears immediately; the first posedge after deassertion acts normally.

Optional Feature:
- Macro GRF_TRACE_EN.
- When defined, every committed write (wr_en=1, not zero-register-suppressed, reset=1) issues a display at the clock edge with the format "time@pc: $reg <= data" (decimal time, hex pc, decimal reg, hex data). This matches the grading trace format.
- When undefined, there is no display and no simulation-only code, and the block is synthesisable unchanged.
- Register state behaviour is identical either way.

Test Plan:
- Reset: hold reset=0 and write reg 3=0x1234 -> no write takes effect; release, read reg 3 -> 0x00000000; busy_cnt=0, rsv_err=0.
- Bypass: wr_en=1, wr_addr=8, wr_data=0xDEADBEEF, rd_addr port0=8 in the same cycle -> rd_data0=0xDEADBEEF before the edge; after the edge, a read of reg 8 still returns 0xDEADBEEF.
- Zero register: write 0xFFFFFFFF to reg 0 and reserve reg 0 -> rd_data=0, rd_busy=0, busy_cnt unchanged, no trace line.
- Scoreboard: reserve reg 5 -> rd_busy=1, busy_cnt=1; next cycle write reg 5=0x42 -> rd_busy=0 during that cycle, busy_cnt=0 after the edge.
- Collision: reg 7 busy, same cycle write 7=0x10 plus rsv 7 -> data 0x10, busy stays 1, rsv_err=0; then rsv 7 again without a write -> rsv_err=1 and stays set.
- Flush: reserve regs 2, 9, 31, then flush=1 with rsv_en=1 on reg 4 -> busy_cnt=0 after the edge; reg 4 not busy.
